// File: rtl/ula_seq.sv
// Sequential ALU: add, sub, and, shift-add multiply on WIDTH-bit unsigned operands.
// Latency: done pulses 1 cycle after an accepted start (add/sub/and), WIDTH+1 cycles (mul).
// Backpressure: start is honoured only while busy=0; starts seen while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low); start/op/e0/e1 request; s/s_hi/c/z registered result
//        held until the next completion; busy (state not idle); done (one-cycle result-valid pulse).
module ula_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] e0,
   input  logic [WIDTH-1:0] e1,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] s_hi,
   output logic             c,
   output logic             z,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      MULT   = 2'd1,
      FIM    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;        // multiplicand
   logic [WIDTH-1:0]     b_q, b_d;        // multiplier, consumed LSB first
   logic [2*WIDTH-1:0]   acc_q, acc_d;    // {upper partial sum, retired product bits}
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     s_q, s_d;
   logic [WIDTH-1:0]     s_hi_q, s_hi_d;
   logic                 c_q, c_d;
   logic                 z_q, z_d;

   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       sub_dif;
   logic [WIDTH:0]       mac_sum;
   logic [2*WIDTH-1:0]   acc_nxt;

   // Datapath. The extra top bit of sub_dif is the borrow, i.e. e0 < e1.
   // mac_sum keeps the carry of the partial add so the right shift loses nothing.
   always_comb begin
      add_sum = {1'b0, e0} + {1'b0, e1};
      sub_dif = {1'b0, e0} - {1'b0, e1};
      mac_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      acc_nxt = {mac_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      s_hi_d  = s_hi_q;
      c_d     = c_q;
      z_d     = z_q;

      case (state_q)
         OCIOSO: begin
            if (start) begin
               a_d = e0;
               b_d = e1;
               if (op == 2'b10) begin
                  state_d = MULT;
                  acc_d   = '0;
                  cnt_d   = '0;
               end else begin
                  // Single-cycle ops resolve straight from the inputs on the accepting edge.
                  state_d = FIM;
                  s_hi_d  = '0;
                  case (op)
                     2'b00: begin
                        s_d = add_sum[WIDTH-1:0];
                        c_d = add_sum[WIDTH];
                     end
                     2'b01: begin
                        s_d = sub_dif[WIDTH-1:0];
                        c_d = sub_dif[WIDTH];
                     end
                     default: begin
                        s_d = e0 & e1;
                        c_d = 1'b0;
                     end
                  endcase
                  z_d = (s_d == '0);
               end
            end
         end
         MULT: begin
            acc_d = acc_nxt;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = FIM;
               s_d     = acc_nxt[WIDTH-1:0];
               s_hi_d  = acc_nxt[2*WIDTH-1:WIDTH];
               c_d     = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
               z_d     = (acc_nxt == '0);
            end
         end
         FIM: begin
            state_d = OCIOSO;
         end
         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OCIOSO;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         s_q     <= '0;
         s_hi_q  <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         s_hi_q  <= s_hi_d;
         c_q     <= c_d;
         z_q     <= z_d;
      end
   end

   assign s    = s_q;
   assign s_hi = s_hi_q;
   assign c    = c_q;
   assign z    = z_q;
   assign busy = (state_q != OCIOSO);
   assign done = (state_q == FIM);

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=16) with hand-computed expected results.
// Latency: measured in negedges after the accepting posedge.
// Backpressure: exercises a start issued while busy.
module tb_ula_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] e0;
   logic [15:0] e1;
   logic [15:0] s;
   logic [15:0] s_hi;
   logic        c;
   logic        z;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   ula_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .e0    (e0),
      .e1    (e1),
      .s     (s),
      .s_hi  (s_hi),
      .c     (c),
      .z     (z),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [15:0] es, input logic [15:0] eh,
                            input logic ec, input logic ez);
      check({tag, "_s"},    32'(s),    32'(es));
      check({tag, "_s_hi"}, 32'(s_hi), 32'(eh));
      check({tag, "_c"},    32'(c),    32'(ec));
      check({tag, "_z"},    32'(z),    32'(ez));
   endtask

   // Called at a negedge with the DUT idle. Returns at the negedge after done, DUT idle again.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input int lat);
      int n;
      n     = 0;
      op    = o;
      e0    = a;
      e1    = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      check({tag, "_latency"},  32'(n), 32'(lat));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"},       32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ndone;
      int first_done;

      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      e0    = '0;
      e1    = '0;

      // Reset state
      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_res("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic add
      run_op("add3p2", 2'b00, 16'd3, 16'd2, 1);
      check_res("add3p2", 16'd5, 16'h0000, 1'b0, 1'b0);

      // 2: add wrap with carry, sub with borrow
      run_op("addwrap", 2'b00, 16'hFFFF, 16'h0001, 1);
      check_res("addwrap", 16'h0000, 16'h0000, 1'b1, 1'b1);
      run_op("sub2m3", 2'b01, 16'd2, 16'd3, 1);
      check_res("sub2m3", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
      run_op("sub9m4", 2'b01, 16'd9, 16'd4, 1);
      check_res("sub9m4", 16'd5, 16'h0000, 1'b0, 1'b0);

      // 3: multiplies
      run_op("mul3x3", 2'b10, 16'd3, 16'd3, 17);
      check_res("mul3x3", 16'd9, 16'h0000, 1'b0, 1'b0);
      run_op("mulmax", 2'b10, 16'hFFFF, 16'hFFFF, 17);
      check_res("mulmax", 16'h0001, 16'hFFFE, 1'b1, 1'b0);
      run_op("mul1234", 2'b10, 16'h1234, 16'h0100, 17);
      check_res("mul1234", 16'h3400, 16'h0012, 1'b1, 1'b0);

      // 4: zero product, and
      run_op("mul0", 2'b10, 16'h0000, 16'h1234, 17);
      check_res("mul0", 16'h0000, 16'h0000, 1'b0, 1'b1);
      run_op("and", 2'b11, 16'hF0F0, 16'h0FF0, 1);
      check_res("and", 16'h00F0, 16'h0000, 1'b0, 1'b0);

      // 5: start during a multiply is dropped; outputs hold during MULT
      op    = 2'b10;
      e0    = 16'd5;
      e1    = 16'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ndone      = 0;
      first_done = 0;
      for (n = 1; n <= 25; n++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first_done == 0) first_done = n;
         end
         if (n == 4) begin
            check("busy_c4", 32'(busy), 32'd1);
            op    = 2'b00;
            e0    = 16'd1;
            e1    = 16'd1;
            start = 1'b1;
         end
         if (n == 5) start = 1'b0;
         if (n == 8) check("hold_s_c8", 32'(s), 32'h00F0);
      end
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_first", 32'(first_done), 32'd17);
      check_res("mul5x7", 16'd35, 16'h0000, 1'b0, 1'b0);

      // 6: async reset mid-multiply
      op    = 2'b10;
      e0    = 16'hFFFF;
      e1    = 16'hFFFF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check_res("arst", 16'h0000, 16'h0000, 1'b0, 1'b0);
      ndone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("arst_nodone", 32'(ndone), 32'd0);
      check("arst_idle", 32'(busy), 32'd0);
      run_op("add1p1", 2'b00, 16'd1, 16'd1, 1);
      check_res("add1p1", 16'd2, 16'h0000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised sequential ALU, successor to the combinational add/mul unit. Supports add, subtract, bitwise AND and iterative shift-add multiply on WIDTH-bit unsigned operands. Uses a start/busy/done handshake, so the multiply costs WIDTH cycles of one adder instead of a full array multiplier. Results and flags are registered and held until the next operation completes.

Parameters:
WIDTH, 16, operand and result-low width (>= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
op  in  2  00 add, 01 sub, 10 mul, 11 and
e0  in  WIDTH  operand A, sampled on accepted start
e1  in  WIDTH  operand B, sampled on accepted start
s  out  WIDTH  result (low half for mul)
s_hi  out  WIDTH  high half of product; 0 for add/sub/and
c  out  1  add: carry out; sub: borrow (e0<e1); mul: s_hi!=0; and: 0
z  out  1  1 when {s_hi,s}==0
busy  out  1  1 whenever state != OCIOSO
done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; s, s_hi, c, z, done = 0; busy = 0; internal operand, accumulator and counter registers = 0. Takes effect immediately, including mid-multiply. The partial result is discarded and no done is issued.
- States:
  - OCIOSO: idle.
  - MULT: iterating.
  - FIM: result presented.
- OCIOSO, start=1: latch e0, e1 and op.
  - op != 10 -> FIM next edge.
  - op = 10 -> MULT, with accumulator=0 and counter=0.
- OCIOSO, start=0: stay; outputs hold.
- MULT, each cycle:
  - If multiplier LSB=1, add the multiplicand to the upper accumulator half, with WIDTH+1-bit internal carry.
  - Shift the {carry,accumulator} pair right by 1; shift the multiplier right by 1.
  - counter+1.
  - After exactly WIDTH cycles (counter==WIDTH-1 on that edge) -> FIM.
- FIM, exactly one cycle: done=1; s, s_hi, c, z updated at the edge entering FIM; next edge -> OCIOSO.
- Latency from the accepting edge to done high:
  - 1 cycle for add/sub/and.
  - WIDTH+1 cycles for mul.
  - Minimum start-to-start spacing is 2 cycles (add/sub/and) or WIDTH+2 cycles (mul).
- start while busy=1 is ignored; it is not queued. Changes on e0/e1/op during busy have no effect.
- Arithmetic:
  - add: s = (e0+e1) mod 2^WIDTH.
  - sub: s = (e0-e1) mod 2^WIDTH.
  - mul: {s_hi,s} = e0*e1 exact, 2*WIDTH bits.
  - and: s = e0&e1.
- Outputs s, s_hi, c, z hold their last value from the FIM entry until the next FIM; they do not change during MULT.
- done never asserts on two consecutive cycles. busy=1 during the cycle done=1.

Test Plan:
1. Reset, then start op=00 e0=3 e1=2 -> next cycle done=1, s=5, s_hi=0, c=0, z=0; busy=0 the cycle after.
2. add e0=0xFFFF e1=0x0001 -> s=0x0000, c=1, z=1. sub e0=2 e1=3 -> s=0xFFFF, c=1, z=0.
3. mul e0=3 e1=3 -> busy for 17 cycles, done on cycle 17 after accept, s=9, s_hi=0, c=0. mul 0xFFFF*0xFFFF -> s=0x0001, s_hi=0xFFFE, c=1.
4. mul e0=0 e1=0x1234 -> s=0, s_hi=0, z=1, latency 17. and 0xF0F0&0x0FF0 -> s=0x00F0.
5. Accept mul 5*7, then pulse start with op=00 e0=1 e1=1 at cycle 4 -> ignored; single done at cycle 17 with s=35; no extra done.
6. Pull rst_n low at cycle 8 of a multiply -> busy=0, outputs 0 immediately (before the next edge), no done. After release, add 1+1 -> s=2 with normal latency.
